// File: rtl/reg_file_pkg.sv
// Shared definitions for the register-file writeback path.
// Contents:
//   REG_DATA_WIDTH_POW : default log2 of the register data width (64 bits)
//   REG_MEM_DEPTH_POW  : default log2 of the register count (32 registers)
//   req_id_t           : identifies the two writeback requesters
package reg_file_pkg;

    localparam int REG_DATA_WIDTH_POW = 6;
    localparam int REG_MEM_DEPTH_POW  = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

endpackage

// File: rtl/reg_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter with its priority pointer.
// Ports:
//   clk_in    : clock, pointer updates on the rising edge
//   rst_in    : asynchronous active-high reset, pointer returns to ALU
//   valid_in  : request vector, indexed by req_id_t
//   grant_out : one-hot (or zero) grant vector, combinational from valid_in
module rr_arbiter2 (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [1:0] valid_in,
    output logic [1:0] grant_out
);
    import reg_file_pkg::*;

    req_id_t ptr_q;
    req_id_t ptr_d;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr_q <= REQ_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // After a grant the loser becomes the favoured requester.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_out[REQ_ALU]) begin
            ptr_d = REQ_MEM;
        end else if (grant_out[REQ_MEM]) begin
            ptr_d = REQ_ALU;
        end
    end

    // Grants are suppressed during reset so nothing can be accepted then.
    always_comb begin
        grant_out = 2'b00;
        if (!rst_in) begin
            if (valid_in[REQ_ALU] && valid_in[REQ_MEM]) begin
                grant_out[ptr_q] = 1'b1;
            end else begin
                grant_out = valid_in;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter between the ALU and the load unit, with a destination
// scoreboard and a contention counter.
// Ports:
//   clk_in, rst_in                  : clock, asynchronous active-high reset
//   alu_valid_in/rd_in/data_in      : ALU writeback request
//   alu_ready_out                   : ALU request accepted this cycle
//   mem_valid_in/rd_in/data_in      : load-unit writeback request
//   mem_ready_out                   : load-unit request accepted this cycle
//   rsv_valid_in, rsv_rd_in         : issue-stage destination reservation
//   rd_out, data_write_out          : registered register-file write port
//   write_en_out                    : registered register-file write enable
//   busy_out                        : scoreboard, bit n = write pending on rn
//   conflict_cnt_out                : saturating count of contention cycles
module reg_wb_arbiter #(
    parameter int REG_DATA_WIDTH_POW = reg_file_pkg::REG_DATA_WIDTH_POW,
    parameter int REG_MEM_DEPTH_POW  = reg_file_pkg::REG_MEM_DEPTH_POW
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                alu_valid_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]        alu_rd_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  alu_data_in,
    output logic                                alu_ready_out,
    input  logic                                mem_valid_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]        mem_rd_in,
    input  logic [(1<<REG_DATA_WIDTH_POW)-1:0]  mem_data_in,
    output logic                                mem_ready_out,
    input  logic                                rsv_valid_in,
    input  logic [REG_MEM_DEPTH_POW-1:0]        rsv_rd_in,
    output logic [REG_MEM_DEPTH_POW-1:0]        rd_out,
    output logic [(1<<REG_DATA_WIDTH_POW)-1:0]  data_write_out,
    output logic                                write_en_out,
    output logic [(1<<REG_MEM_DEPTH_POW)-1:0]   busy_out,
    output logic [7:0]                          conflict_cnt_out
);
    import reg_file_pkg::*;

    localparam int DW   = 1 << REG_DATA_WIDTH_POW;
    localparam int RW   = REG_MEM_DEPTH_POW;
    localparam int NREG = 1 << REG_MEM_DEPTH_POW;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]      req_valid;
    logic [1:0]      grant;
    logic            xfer;
    logic [RW-1:0]   sel_rd;
    logic [DW-1:0]   sel_data;

    logic            wen_q, wen_d;
    logic [RW-1:0]   rd_q, rd_d;
    logic [DW-1:0]   data_q, data_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [7:0]      cnt_q, cnt_d;

    assign req_valid = {mem_valid_in, alu_valid_in};

    rr_arbiter2 u_rr (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid_in  (req_valid),
        .grant_out (grant)
    );

    assign alu_ready_out = grant[REQ_ALU];
    assign mem_ready_out = grant[REQ_MEM];
    assign xfer          = |grant;

    // Grants are one-hot, so a simple select picks the winning payload.
    assign sel_rd   = grant[REQ_MEM] ? mem_rd_in   : alu_rd_in;
    assign sel_data = grant[REQ_MEM] ? mem_data_in : alu_data_in;

    always_comb begin
        wen_d  = xfer && (sel_rd != '0);
        rd_d   = rd_q;
        data_d = data_q;
        if (xfer) begin
            rd_d   = sel_rd;
            data_d = sel_data;
        end

        // Clear first, then set, so a fresh reservation overrides a
        // completing write to the same register.
        busy_d = busy_q;
        if (wen_d) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (rsv_valid_in && (rsv_rd_in != '0)) begin
            busy_d[rsv_rd_in] = 1'b1;
        end
        busy_d[0] = 1'b0;

        cnt_d = (alu_valid_in && mem_valid_in) ? sat_inc8(cnt_q) : cnt_q;
    end

    // Registered write port, scoreboard and counter.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wen_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            wen_q  <= wen_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign write_en_out     = wen_q;
    assign rd_out           = rd_q;
    assign data_write_out   = data_q;
    assign busy_out         = busy_q;
    assign conflict_cnt_out = cnt_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_reg_wb_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        alu_valid_in = 1'b0;
    logic [4:0]  alu_rd_in = '0;
    logic [63:0] alu_data_in = '0;
    logic        alu_ready_out;
    logic        mem_valid_in = 1'b0;
    logic [4:0]  mem_rd_in = '0;
    logic [63:0] mem_data_in = '0;
    logic        mem_ready_out;
    logic        rsv_valid_in = 1'b0;
    logic [4:0]  rsv_rd_in = '0;
    logic [4:0]  rd_out;
    logic [63:0] data_write_out;
    logic        write_en_out;
    logic [31:0] busy_out;
    logic [7:0]  conflict_cnt_out;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_fav_mem;   // 1 when the load unit wins the next contention
    bit          m_wen;
    int          m_rd;
    logic [63:0] m_data;
    bit          m_busy [32];
    int          m_cnt;

    always #5 clk_in = ~clk_in;

    reg_wb_arbiter dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .alu_valid_in     (alu_valid_in),
        .alu_rd_in        (alu_rd_in),
        .alu_data_in      (alu_data_in),
        .alu_ready_out    (alu_ready_out),
        .mem_valid_in     (mem_valid_in),
        .mem_rd_in        (mem_rd_in),
        .mem_data_in      (mem_data_in),
        .mem_ready_out    (mem_ready_out),
        .rsv_valid_in     (rsv_valid_in),
        .rsv_rd_in        (rsv_rd_in),
        .rd_out           (rd_out),
        .data_write_out   (data_write_out),
        .write_en_out     (write_en_out),
        .busy_out         (busy_out),
        .conflict_cnt_out (conflict_cnt_out)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
        end
    endtask

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        m_fav_mem = 0;
        m_wen     = 0;
        m_rd      = 0;
        m_data    = '0;
        m_cnt     = 0;
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
    endtask

    // Asserts reset away from a clock edge with both requesters valid, checks
    // the immediate effect, then releases it between edges.
    task automatic do_reset();
        alu_valid_in = 1'b1;
        mem_valid_in = 1'b1;
        rst_in = 1'b1;
        #1;
        check_eq("rst_wen",   write_en_out,     0);
        check_eq("rst_rd",    rd_out,           0);
        check_eq("rst_data",  data_write_out,   0);
        check_eq("rst_busy",  busy_out,         0);
        check_eq("rst_cnt",   conflict_cnt_out, 0);
        check_eq("rst_aready", alu_ready_out,   0);
        check_eq("rst_mready", mem_ready_out,   0);
        alu_valid_in = 1'b0;
        mem_valid_in = 1'b0;
        rsv_valid_in = 1'b0;
        model_reset();
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    // One clock cycle: drive inputs, check all outputs at the falling edge,
    // advance the model at the rising edge. Called at rising edge + 1.
    task automatic step(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                        input logic rv, input logic [4:0] rrd,
                        output logic ga, output logic gm);
        int wrd;
        alu_valid_in = av; alu_rd_in = ard; alu_data_in = ad;
        mem_valid_in = mv; mem_rd_in = mrd; mem_data_in = md;
        rsv_valid_in = rv; rsv_rd_in = rrd;
        @(negedge clk_in);
        ga = av && (!mv || !m_fav_mem);
        gm = mv && (!av || m_fav_mem);
        check_eq("alu_ready", alu_ready_out, ga);
        check_eq("mem_ready", mem_ready_out, gm);
        check_eq("write_en",  write_en_out, m_wen);
        if (m_wen) begin
            check_eq("rd_out",   rd_out, m_rd);
            check_eq("data_out", data_write_out, m_data);
        end
        check_eq("busy",     busy_out, model_busy_vec());
        check_eq("conflict", conflict_cnt_out, m_cnt);
        @(posedge clk_in);
        if (av && mv && m_cnt < 255) m_cnt++;
        if (ga || gm) begin
            wrd       = gm ? int'(mrd) : int'(ard);
            m_wen     = (wrd != 0);
            m_rd      = wrd;
            m_data    = gm ? md : ad;
            m_fav_mem = ga;
            if (wrd != 0) m_busy[wrd] = 0;
        end else begin
            m_wen = 0;
        end
        if (rv && rrd != 0) m_busy[rrd] = 1;
        #1;
    endtask

    initial begin
        logic ga, gm;
        logic av, mv, rv;
        logic [4:0] ard, mrd, rrd;
        logic [63:0] ad, md;

        #2;
        do_reset();

        // Single ALU write
        step(1, 5, 64'hDEAD, 0, 0, 0, 0, 0, ga, gm);
        check_eq("alu_wr_wen",  write_en_out, 1);
        check_eq("alu_wr_rd",   rd_out, 5);
        check_eq("alu_wr_data", data_write_out, 64'hDEAD);

        // Four contention cycles alternate starting with the ALU
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 64'h11, 1, 2, 64'h22, 0, 0, ga, gm);
            check_eq("alt_grant_mem", gm, (i % 2) == 1);
        end
        check_eq("alt_cnt", conflict_cnt_out, 4);

        // Reservation held until the load unit writes it
        step(0, 0, 0, 0, 0, 0, 1, 7, ga, gm);
        check_eq("rsv7_set", busy_out[7], 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
        step(0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
        check_eq("rsv7_hold", busy_out[7], 1);
        step(0, 0, 0, 1, 7, 64'h77, 0, 0, ga, gm);
        check_eq("rsv7_clear", busy_out[7], 0);

        // Reservation and completing write on the same edge
        step(1, 9, 64'h99, 0, 0, 0, 1, 9, ga, gm);
        check_eq("rsv9_busy", busy_out[9], 1);
        check_eq("rsv9_wen",  write_en_out, 1);

        // Write to r0 is swallowed
        do_reset();
        step(1, 0, 64'h1234, 0, 0, 0, 1, 0, ga, gm);
        check_eq("r0_wen",  write_en_out, 0);
        check_eq("r0_busy", busy_out, 0);

        // Reset right after an accepted write drops it
        step(0, 0, 0, 1, 3, 64'h33, 0, 0, ga, gm);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
        step(1, 4, 64'h44, 1, 6, 64'h66, 0, 0, ga, gm);
        check_eq("post_rst_alu_first", write_en_out && rd_out == 4, 1);

        // Saturating contention counter
        for (int i = 0; i < 300; i++) begin
            step(1, 4, 64'h44, 1, 6, 64'h66, 0, 0, ga, gm);
        end
        check_eq("cnt_sat", conflict_cnt_out, 255);

        // Randomized traffic; a refused requester keeps its request stable
        do_reset();
        av = 0; mv = 0; ga = 0; gm = 0;
        ard = 0; mrd = 0; ad = '0; md = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!(av && !ga)) begin
                av  = ($urandom_range(0, 1) == 1);
                ard = 5'($urandom_range(0, 31));
                ad  = {$urandom, $urandom};
            end
            if (!(mv && !gm)) begin
                mv  = ($urandom_range(0, 1) == 1);
                mrd = 5'($urandom_range(0, 31));
                md  = {$urandom, $urandom};
            end
            rv  = ($urandom_range(0, 3) == 0);
            rrd = 5'($urandom_range(0, 31));
            step(av, ard, ad, mv, mrd, md, rv, rrd, ga, gm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter REG_DATA_WIDTH_POW, default 6, log2 of data width (DW = 64).
REQ-002 Parameter REG_MEM_DEPTH_POW, default 5, log2 of register count (RW = 5, 32 registers).
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 alu_valid_in  input  1  ALU writeback request.
REQ-006 alu_rd_in  input  RW  ALU destination index.
REQ-007 alu_data_in  input  DW  ALU writeback data.
REQ-008 alu_ready_out  output  1  ALU request accepted this cycle.
REQ-009 mem_valid_in, mem_rd_in, mem_data_in  input  1/RW/DW  load-unit writeback request, index, data.
REQ-010 mem_ready_out  output  1  load-unit request accepted this cycle.
REQ-011 rsv_valid_in  input  1  issue-stage reservation of a destination register.
REQ-012 rsv_rd_in  input  RW  reserved index.
REQ-013 rd_out  output  RW  register-file write index.
REQ-014 data_write_out  output  DW  register-file write data.
REQ-015 write_en_out  output  1  register-file write enable.
REQ-016 busy_out  output  2^RW  scoreboard; bit n = register n has a write pending.
REQ-017 conflict_cnt_out  output  8  count of cycles in which a valid requester was refused.

Function
REQ-018 Transfer = valid && ready on the same rising edge; at most one transfer per cycle.
REQ-019 Ready outputs are combinational from the valid inputs and the priority pointer; a ready never asserts without its valid.
REQ-020 Single valid requester: that requester is granted.
REQ-021 Both valid: the requester selected by the priority pointer is granted; the other holds its request stable until granted.
REQ-022 Priority pointer points to the non-granted requester after every transfer; with no transfer it is unchanged.
REQ-023 Write port registered: a transfer at edge N drives rd_out, data_write_out and write_en_out=1 during cycle N+1; without a transfer, write_en_out=0 in the following cycle.
REQ-024 A transfer with rd=0 is accepted but produces write_en_out=0 and no scoreboard change.
REQ-025 Scoreboard set: rsv_valid_in with rsv_rd_in!=0 sets busy bit rsv_rd_in at the edge.
REQ-026 Scoreboard clear: a transfer with rd!=0 clears busy bit rd at the transfer edge.
REQ-027 Set and clear of the same bit at one edge: set wins (newer reservation).
REQ-028 busy_out bit 0 is constant 0.
REQ-029 conflict_cnt_out increments by 1 in each cycle where both requesters are valid; it saturates at 255.
REQ-030 A transfer with rd!=0 to a register whose busy bit is already clear is legal: the write occurs and the bit stays clear.

Reset
REQ-031 While rst_in=1, without waiting for a clock edge: write_en_out=0, rd_out=0, data_write_out=0, busy_out=0, conflict_cnt_out=0, pointer=ALU.
REQ-032 While rst_in=1, both ready outputs are 0.
REQ-033 A transfer registered before reset asserts is discarded; no write appears after reset releases.
REQ-034 The first arbitration after reset favours ALU.

Structure
REQ-035 Shared package reg_file_pkg holds REG_DATA_WIDTH_POW/REG_MEM_DEPTH_POW defaults and enum req_id_t {REQ_ALU, REQ_MEM}.
REQ-036 The two-input round-robin grant logic and pointer are one sub-module, rr_arbiter2; the scoreboard, output register and counter stay in the top module.

Verification
REQ-037 Reset, then alu_valid_in=1, rd=5, data=0xDEAD -> alu_ready_out=1; next cycle write_en_out=1, rd_out=5, data_write_out=0xDEAD.
REQ-038 Both valid for 4 cycles, ALU rd=1, MEM rd=2 -> grants alternate ALU, MEM, ALU, MEM; conflict_cnt_out=4.
REQ-039 rsv rd=7, then MEM writes rd=7 3 cycles later -> busy_out[7]=1 for those cycles, 0 after the transfer edge.
REQ-040 rsv rd=9 and ALU transfer rd=9 on the same edge -> busy_out[9]=1 afterwards; write_en_out=1 next cycle.
REQ-041 ALU transfer rd=0, rsv rd=0 -> alu_ready_out=1, write_en_out=0 next cycle, busy_out=0.
REQ-042 Assert rst_in mid-cycle after an accepted transfer -> outputs immediately 0, no write after release; 300 contention cycles -> conflict_cnt_out=255.
